// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the fetch stage: widths, the canonical NOP
// and the {instr, pc} entry carried between fetch and decode.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    localparam fetch_entry_t NOP_ENTRY = '{instr: NOP_INSTR, pc: '0};

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries. The head entry lives in its own
// register so decode sees a registered {instr, pc} with no path from push data.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty,
    output logic         full
);

    fetch_entry_t  mem [DEPTH];
    fetch_entry_t  head_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_inc;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign do_pop     = pop && (count_reg != '0);
    assign do_push    = push && ((count_reg != CW'(DEPTH)) || do_pop);
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= NOP_ENTRY;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_inc;
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
            // The next head is either the stored successor or the word arriving now.
            if (do_pop && (count_reg > CW'(1))) begin
                head_reg <= mem[rd_ptr_inc];
            end else if (do_push && ((count_reg == '0) || do_pop)) begin
                head_reg <= wdata;
            end
        end
    end

    assign head  = head_reg;
    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited word reads to imem,
// buffers in-order responses and discards those made stale by a redirect.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   rsp_pc_reg, rsp_pc_next;
    logic [CW-1:0] out_cnt_reg, out_cnt_next;
    logic [CW-1:0] drop_cnt_reg, drop_cnt_next;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   in_use;
    logic          accept, rsp_ok, keep, pop;
    logic          fifo_empty, fifo_full;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    // Outstanding requests (including ones to be dropped) plus buffered words
    // bound the buffer occupancy, so credit is taken from both.
    assign in_use         = {1'b0, out_cnt_reg} + {1'b0, fifo_cnt};
    assign imem_req_valid = rst_n && !redirect_valid && (in_use < CREDIT_MAX);
    assign imem_addr      = fetch_pc_reg;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_ok         = imem_rsp_valid && (out_cnt_reg != '0);
    assign keep           = rsp_ok && (drop_cnt_reg == '0) && !redirect_valid;
    assign instr_valid    = !fifo_empty;
    assign pop            = instr_valid && instr_ready;
    assign instr          = head.instr;
    assign pc             = head.pc;
    assign push_entry     = '{instr: imem_rsp_data, pc: rsp_pc_reg};

    always_comb begin
        out_cnt_next  = out_cnt_reg + CW'(accept) - CW'(rsp_ok);
        fetch_pc_next = fetch_pc_reg;
        rsp_pc_next   = rsp_pc_reg;
        drop_cnt_next = drop_cnt_reg;
        if (redirect_valid) begin
            fetch_pc_next = word_align(redirect_pc);
            rsp_pc_next   = word_align(redirect_pc);
            drop_cnt_next = out_cnt_next;
        end else begin
            if (accept) fetch_pc_next = fetch_pc_reg + 32'd4;
            if (keep)   rsp_pc_next   = rsp_pc_reg + 32'd4;
            if (rsp_ok && (drop_cnt_reg != '0)) drop_cnt_next = drop_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg <= RESET_PC;
            rsp_pc_reg   <= RESET_PC;
            out_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            rsp_pc_reg   <= rsp_pc_next;
            out_cnt_reg  <= out_cnt_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (keep),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (push_entry),
        .head  (head),
        .count (fifo_cnt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // A response with nothing outstanding is a memory protocol error.
    a_rsp_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (out_cnt_reg != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(keep && fifo_full && !pop));

endmodule
